// File: rtl/cla_pipe_adder_if.sv
// Operand and result valid/ready streams for the pipelined CLA adder.
// The master side issues operands and accepts results.
interface cla_pipe_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// K-stage pipelined carry-lookahead adder/subtractor, one W-bit
// segment resolved per stage, with a global stall on back-pressure.
module cla_pipe_adder #(
  parameter int N = 32,
  parameter int K = 4
) (
  input logic             clk,
  input logic             reset_n,
  cla_pipe_adder_if.slave bus
);
  localparam int W  = (K >= 1 && K <= N) ? N / K : 1;
  localparam int KA = (K > 1) ? K - 1 : 1;

  if (K < 1 || K > N || (N % K) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: N must split into K equal segments");
  end

  // Lookahead carries of one segment, all expressed against c0.
  function automatic logic [W:0] f_carry(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c0
  );
    logic [W:0] c;
    logic       gg;
    logic       pp;
    c[0] = c0;
    gg   = 1'b0;
    pp   = 1'b1;
    for (int i = 0; i < W; i++) begin
      gg     = (a[i] & b[i]) | ((a[i] ^ b[i]) & gg);
      pp     = pp & (a[i] ^ b[i]);
      c[i+1] = gg | (pp & c0);
    end
    return c;
  endfunction

  logic         w_stall;
  logic         w_acc;

  logic [K-1:0] r_v;
  logic [K-1:0] r_c;
  logic         r_ovf;
  logic [N-1:0] r_sum [K];
  logic [N-1:0] r_a   [KA];
  logic [N-1:0] r_b   [KA];

  logic [K-1:0] w_nv;
  logic [K-1:0] w_nc;
  logic         w_novf;
  logic [N-1:0] w_nsum [K];
  logic [N-1:0] w_na   [KA];
  logic [N-1:0] w_nb   [KA];

  assign w_stall = r_v[K-1] & ~bus.out_ready;
  assign w_acc   = bus.in_valid & ~w_stall;

  assign bus.in_ready  = ~w_stall;
  assign bus.out_valid = r_v[K-1];
  assign bus.s         = r_sum[K-1];
  assign bus.cout      = r_c[K-1];
  assign bus.ovf       = r_ovf;

  // Sums enter at the top and shift down W per stage; the unresolved
  // operand bits shift down W per stage so the next segment sits at bit 0.
  for (genvar j = 0; j < K; j++) begin : g_st
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [N-1:0] w_sin;
    logic         w_vin;
    logic         w_cin;
    logic [W-1:0] w_sa;
    logic [W-1:0] w_sb;
    logic [W-1:0] w_ss;
    logic [W:0]   w_c;

    if (j == 0) begin : g_head
      assign w_a   = bus.x;
      assign w_b   = bus.y ^ {N{bus.sub}};
      assign w_sin = '0;
      assign w_vin = w_acc;
      assign w_cin = bus.cin ^ bus.sub;
    end else begin : g_body
      assign w_a   = r_a[j-1];
      assign w_b   = r_b[j-1];
      assign w_sin = r_sum[j-1];
      assign w_vin = r_v[j-1];
      assign w_cin = r_c[j-1];
    end

    assign w_sa = W'(w_a);
    assign w_sb = W'(w_b);
    assign w_c  = f_carry(w_sa, w_sb, w_cin);
    assign w_ss = w_sa ^ w_sb ^ w_c[W-1:0];

    assign w_nv[j]   = w_vin;
    assign w_nc[j]   = w_c[W];
    assign w_nsum[j] = (w_sin >> W) | (N'(w_ss) << (N - W));

    if (j < K - 1) begin : g_pass
      assign w_na[j] = w_a >> W;
      assign w_nb[j] = w_b >> W;
    end else begin : g_tail
      assign w_novf = w_c[W] ^ w_c[W-1];
    end
  end

  if (K == 1) begin : g_no_ops
    assign w_na[0] = '0;
    assign w_nb[0] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < K; i++) begin
        r_sum[i] <= '0;
      end
      for (int i = 0; i < KA; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else if (!w_stall) begin
      r_v   <= w_nv;
      r_c   <= w_nc;
      r_ovf <= w_novf;
      for (int i = 0; i < K; i++) begin
        r_sum[i] <= w_nsum[i];
      end
      for (int i = 0; i < KA; i++) begin
        r_a[i] <= w_na[i];
        r_b[i] <= w_nb[i];
      end
    end
  end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases on small configurations
// and a randomized back-pressured stream against a reference model.
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst_n;
  logic rst84_n;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cla_pipe_adder_if #(.N(8))  b82 ();
  cla_pipe_adder_if #(.N(8))  b84 ();
  cla_pipe_adder_if #(.N(16)) b161 ();
  cla_pipe_adder_if #(.N(32)) b324 ();

  cla_pipe_adder #(.N(8), .K(2)) u82 (
    .clk(clk), .reset_n(rst_n), .bus(b82)
  );
  cla_pipe_adder #(.N(8), .K(4)) u84 (
    .clk(clk), .reset_n(rst84_n), .bus(b84)
  );
  cla_pipe_adder #(.N(16), .K(1)) u161 (
    .clk(clk), .reset_n(rst_n), .bus(b161)
  );
  cla_pipe_adder #(.N(32), .K(4)) u324 (
    .clk(clk), .reset_n(rst_n), .bus(b324)
  );

  // {s, cout, ovf} from plain integer arithmetic on the operand values.
  function automatic logic [33:0] ref32(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci,
    input logic        sb
  );
    longint ua, ub, sa, sbv, sv;
    logic [31:0] s;
    logic co, ov;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      s  = a - b - 32'(ci);
      co = (ua >= ub + longint'(ci));
      sv = sa - sbv - longint'(ci);
    end else begin
      s  = a + b + 32'(ci);
      co = (ua + ub + longint'(ci)) >= 64'sh1_0000_0000;
      sv = sa + sbv + longint'(ci);
    end
    ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    return {s, co, ov};
  endfunction

  task automatic drive82(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic ci,
                         input logic sb);
    b82.in_valid = v; b82.x = a; b82.y = b;
    b82.cin = ci; b82.sub = sb;
  endtask

  task automatic drive84(input logic v, input logic [7:0] a,
                         input logic [7:0] b);
    b84.in_valid = v; b84.x = a; b84.y = b;
    b84.cin = 1'b0; b84.sub = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rst84_n = 1'b0;
    step();
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf, b82.in_ready}
        !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      begin n_fail++;
      $display("FAIL reset82: got v=%b s=%h c=%b o=%b rdy=%b want 0 00 0 0 1",
               b82.out_valid, b82.s, b82.cout, b82.ovf, b82.in_ready); end
    n_run++;
    if ({b324.out_valid, b324.s, b324.cout, b324.ovf, b324.in_ready}
        !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
      begin n_fail++;
      $display("FAIL reset324: got v=%b s=%h c=%b o=%b rdy=%b want 0 0 0 0 1",
               b324.out_valid, b324.s, b324.cout, b324.ovf, b324.in_ready); end
    rst_n = 1'b1;
    rst84_n = 1'b1;
  endtask

  task automatic test_add_basic;
    b82.out_ready = 1'b1;
    drive82(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
    step();
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_run++;
    if (b82.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL basic_early: got v=%b want 0", b82.out_valid); end
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h4B, 1'b0, 1'b0})
      begin n_fail++;
      $display("FAIL basic: got v=%b s=%h c=%b o=%b want 1 4b 0 0",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
  endtask

  task automatic test_back_to_back;
    b82.out_ready = 1'b1;
    drive82(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    step();
    drive82(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
    step();
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h00, 1'b1, 1'b0})
      begin n_fail++;
      $display("FAIL b2b_carry: got v=%b s=%h c=%b o=%b want 1 00 1 0",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h80, 1'b0, 1'b1})
      begin n_fail++;
      $display("FAIL b2b_ovf: got v=%b s=%h c=%b o=%b want 1 80 0 1",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
    n_run++;
    if (b82.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_drain: got v=%b want 0", b82.out_valid); end
  endtask

  task automatic test_subtract;
    b82.out_ready = 1'b1;
    drive82(1'b1, 8'h05, 8'h07, 1'b0, 1'b1);
    step();
    drive82(1'b1, 8'h80, 8'h01, 1'b0, 1'b1);
    step();
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'hFE, 1'b0, 1'b0})
      begin n_fail++;
      $display("FAIL sub_borrow: got v=%b s=%h c=%b o=%b want 1 fe 0 0",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h7F, 1'b1, 1'b1})
      begin n_fail++;
      $display("FAIL sub_ovf: got v=%b s=%h c=%b o=%b want 1 7f 1 1",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
  endtask

  task automatic test_stall;
    b82.out_ready = 1'b0;
    drive82(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0);
    step();
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    drive82(1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    #1;
    n_run++;
    if (b82.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL stall_rdy: got %b want 0", b82.in_ready); end
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h4B, 1'b0, 1'b0})
      begin n_fail++;
      $display("FAIL stall_hold: got v=%b s=%h c=%b o=%b want 1 4b 0 0",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    b82.out_ready = 1'b1;
    #1;
    n_run++;
    if (b82.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL release_rdy: got %b want 1", b82.in_ready); end
    step();
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_run++;
    if (b82.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_bubble: got v=%b want 0", b82.out_valid); end
    step();
    n_run++;
    if ({b82.out_valid, b82.s, b82.cout, b82.ovf} !== {1'b1, 8'h02, 1'b0, 1'b0})
      begin n_fail++;
      $display("FAIL stall_next: got v=%b s=%h c=%b o=%b want 1 02 0 0",
               b82.out_valid, b82.s, b82.cout, b82.ovf); end
    step();
    n_run++;
    if (b82.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall_dup: got v=%b want 0", b82.out_valid); end
  endtask

  task automatic test_k1;
    b161.out_ready = 1'b1;
    b161.in_valid = 1'b1;
    b161.x = 16'hFFFF; b161.y = 16'hFFFF;
    b161.cin = 1'b1; b161.sub = 1'b0;
    step();
    b161.in_valid = 1'b0;
    n_run++;
    if ({b161.out_valid, b161.s, b161.cout, b161.ovf}
        !== {1'b1, 16'hFFFF, 1'b1, 1'b0})
      begin n_fail++;
      $display("FAIL k1: got v=%b s=%h c=%b o=%b want 1 ffff 1 0",
               b161.out_valid, b161.s, b161.cout, b161.ovf); end
    step();
    n_run++;
    if (b161.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL k1_drain: got v=%b want 0", b161.out_valid); end
  endtask

  task automatic test_reset_midflight;
    b84.out_ready = 1'b1;
    drive84(1'b1, 8'h90, 8'h90);
    step();
    drive84(1'b1, 8'h11, 8'h22);
    step();
    drive84(1'b1, 8'h33, 8'h44);
    step();
    drive84(1'b0, 8'h00, 8'h00);
    step();
    n_run++;
    if ({b84.out_valid, b84.s, b84.cout, b84.ovf} !== {1'b1, 8'h20, 1'b1, 1'b1})
      begin n_fail++;
      $display("FAIL k4_latency: got v=%b s=%h c=%b o=%b want 1 20 1 1",
               b84.out_valid, b84.s, b84.cout, b84.ovf); end
    #1;
    rst84_n = 1'b0;
    #1;
    n_run++;
    if ({b84.out_valid, b84.s, b84.cout, b84.ovf} !== {1'b0, 8'h00, 1'b0, 1'b0})
      begin n_fail++;
      $display("FAIL async_reset: got v=%b s=%h c=%b o=%b want 0 00 0 0",
               b84.out_valid, b84.s, b84.cout, b84.ovf); end
    step();
    @(negedge clk);
    rst84_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_run++;
      if (b84.out_valid !== 1'b0) begin n_fail++;
        $display("FAIL post_reset cycle %0d: got v=%b want 0",
                 i, b84.out_valid); end
    end
  endtask

  task automatic test_random_stream;
    logic [33:0] q[$];
    logic [33:0] exp;
    logic [33:0] obs;
    logic [33:0] held;
    logic        held_v;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    held_v = 1'b0; held = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (sent < 1000) begin
        b324.in_valid = 1'($urandom_range(0, 1));
        b324.x   = $urandom;
        b324.y   = $urandom;
        b324.cin = 1'($urandom_range(0, 1));
        b324.sub = 1'($urandom_range(0, 1));
      end else begin
        b324.in_valid = 1'b0;
      end
      b324.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      obs = {b324.s, b324.cout, b324.ovf};
      n_run++;
      if (b324.in_ready !== ~(b324.out_valid & ~b324.out_ready)) begin
        n_fail++;
        $display("FAIL in_ready cycle %0d: got %b ov=%b or=%b",
                 cyc, b324.in_ready, b324.out_valid, b324.out_ready);
      end
      if (held_v) begin
        n_run++;
        if (b324.out_valid !== 1'b1 || obs !== held) begin
          n_fail++;
          $display("FAIL hold cycle %0d: got v=%b %h want 1 %h",
                   cyc, b324.out_valid, obs, held);
        end
      end
      if (b324.in_valid === 1'b1 && b324.in_ready === 1'b1) begin
        q.push_back(ref32(b324.x, b324.y, b324.cin, b324.sub));
        sent++;
      end
      if (b324.out_valid === 1'b1 && b324.out_ready === 1'b1) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat cycle %0d: got %h want none", cyc, obs);
        end else begin
          exp = q.pop_front();
          got++;
          if (obs !== exp) begin
            n_fail++;
            $display("FAIL stream beat %0d: got %h want %h", got, obs, exp);
          end
        end
      end
      held_v = (b324.out_valid === 1'b1) && (b324.out_ready === 1'b0);
      held = obs;
      step();
      cyc++;
    end
    b324.in_valid = 1'b0;
    n_run++;
    if (sent != 1000 || got != 1000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got sent=%0d recv=%0d left=%0d want 1000 1000 0",
               sent, got, q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive82(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive84(1'b0, 8'h00, 8'h00);
    b82.out_ready = 1'b0;
    b84.out_ready = 1'b0;
    b161.in_valid = 1'b0; b161.x = '0; b161.y = '0;
    b161.cin = 1'b0; b161.sub = 1'b0; b161.out_ready = 1'b0;
    b324.in_valid = 1'b0; b324.x = '0; b324.y = '0;
    b324.cin = 1'b0; b324.sub = 1'b0; b324.out_ready = 1'b0;
    test_reset();
    test_add_basic();
    test_back_to_back();
    test_subtract();
    test_stall();
    test_k1();
    test_reset_midflight();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
